// File: rtl/dac_update_arbiter.sv
// dac_update_arbiter: shares one AD5541 SPI serializer among NUM_REQ requesters.
// Define DAC_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dac_update_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DV_HOLD = 2,
    parameter int MIN_GAP = 16,
    parameter int TIMEOUT = 2047
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   done,
    output logic                   dac_dv,
    output logic [15:0]            dac_data,
    input  logic                   dac_csn,
    output logic                   busy,
    output logic [2:0]             owner,
    output logic                   timeout_err,
    input  logic                   err_clr
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_END, GAP} state_t;

    localparam logic [11:0] HOLD_LAST = 12'(DV_HOLD - 1);
    localparam logic [11:0] GAP_LAST  = 12'(MIN_GAP == 0 ? 0 : MIN_GAP - 1);
    localparam logic [11:0] TO_LIMIT  = 12'(TIMEOUT);

    state_t               state_q, state_d;
    logic [11:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 done_q, done_d;
    logic                 dv_q, dv_d;
    logic                 err_q, err_d;
    logic [15:0]          data_q, data_d;
    logic [2:0]           owner_q, owner_d;
    logic                 csn_meta_q, csn_s_q;
    logic [2:0]           win;
    logic                 found;
    logic [7:0]           req_pad;
    logic [127:0]         data_pad;

    assign req_pad  = 8'(req);
    assign data_pad = 128'(req_data);

`ifdef DAC_ARB_FIXED_PRIO_EN
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_pad[3'(i)]) begin
                win   = 3'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 3'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_pad[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign ptr_d = (state_q == IDLE && found) ? win : ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= 3'(NUM_REQ - 1);
        else          ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        done_d   = 1'b0;
        dv_d     = dv_q;
        data_d   = data_q;
        owner_d  = owner_q;
        err_d    = err_clr ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    dv_d    = 1'b1;
                    data_d  = data_pad[{win, 4'b0000} +: 16];
                    owner_d = win;
                    for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (win == 3'(i));
                end
            end
            LOAD: begin
                if (cnt_q >= HOLD_LAST) begin
                    dv_d    = 1'b0;
                    state_d = WAIT_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            WAIT_START: begin
                if (!csn_s_q) begin
                    state_d = WAIT_END;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            WAIT_END: begin
                if (csn_s_q) begin
                    done_d  = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + 12'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= 1'b0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            owner_q    <= '0;
            csn_meta_q <= 1'b1;
            csn_s_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            data_q     <= data_d;
            owner_q    <= owner_d;
            csn_meta_q <= dac_csn;
            csn_s_q    <= csn_meta_q;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign dac_dv      = dv_q;
    assign dac_data    = data_q;
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_dac_update_arbiter.sv
// tb_dac_update_arbiter: scoreboard bench for dac_update_arbiter with a behavioural serializer.
module tb_dac_update_arbiter;
    typedef struct packed {logic [2:0] owner; logic [15:0] data;} exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0 = 1'b0, rst_n1 = 1'b0;
    logic [3:0]  req0 = '0;
    logic [63:0] rd0 = '0;
    logic [1:0]  req1 = '0;
    logic [31:0] rd1 = '0;
    logic        err_clr0 = 1'b0, err_clr1 = 1'b0;
    logic [3:0]  grant0;
    logic [1:0]  grant1;
    logic        done0, dv0, busy0, err0, done1, dv1, busy1, err1;
    logic [15:0] data0, data1;
    logic [2:0]  owner0, owner1;
    logic        csn0 = 1'b1, csn1 = 1'b1, dvp0 = 1'b0, dvp1 = 1'b0;
    int          sc0 = 0, sc1 = 0;
    int          ser_mode = 0;
    int          tests = 0, fails = 0;
    exp_t        sb[$];

    dac_update_arbiter u_dut0 (
        .clk(clk), .reset_n(rst_n0), .req(req0), .req_data(rd0), .grant(grant0), .done(done0),
        .dac_dv(dv0), .dac_data(data0), .dac_csn(csn0), .busy(busy0), .owner(owner0),
        .timeout_err(err0), .err_clr(err_clr0)
    );

    dac_update_arbiter #(.NUM_REQ(2), .DV_HOLD(2), .MIN_GAP(0), .TIMEOUT(2047)) u_dut1 (
        .clk(clk), .reset_n(rst_n1), .req(req1), .req_data(rd1), .grant(grant1), .done(done1),
        .dac_dv(dv1), .dac_data(data1), .dac_csn(csn1), .busy(busy1), .owner(owner1),
        .timeout_err(err1), .err_clr(err_clr1)
    );

    // Serializer model: csn drops after the dv falling edge and stays low 17 cycles.
    // ser_mode 1 never starts a frame, ser_mode 2 never ends one.
    always @(posedge clk) begin
        dvp0 <= dv0;
        if (dvp0 && !dv0 && ser_mode != 1) begin csn0 <= 1'b0; sc0 <= 16; end
        else if (sc0 > 0) sc0 <= sc0 - 1;
        else if (ser_mode != 2) csn0 <= 1'b1;
        dvp1 <= dv1;
        if (dvp1 && !dv1) begin csn1 <= 1'b0; sc1 <= 16; end
        else if (sc1 > 0) sc1 <= sc1 - 1;
        else csn1 <= 1'b1;
    end

    task automatic wait_grant(input bit d, input int bound, output int cyc);
        cyc = 0;
        while (!(d ? |grant1 : |grant0) && cyc < bound) begin @(negedge clk); cyc++; end
        if (!(d ? |grant1 : |grant0)) cyc = -1;
    endtask

    task automatic wait_idle0(input int bound, output int n);
        n = 0;
        while (busy0 && n < bound) begin @(negedge clk); n++; end
    endtask

    task automatic pulse_reset0;
        @(negedge clk); rst_n0 = 1'b0;
        @(negedge clk); rst_n0 = 1'b1;
    endtask

    task automatic test_reset;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({grant0, done0, dv0, data0, busy0, owner0, err0} !== '0) begin
            fails++; $display("FAIL reset0: got %h required 0", {grant0, done0, dv0, data0, busy0, owner0, err0});
        end
        tests++;
        if ({grant1, done1, dv1, data1, busy1, owner1, err1} !== '0) begin
            fails++; $display("FAIL reset1: got %h required 0", {grant1, done1, dv1, data1, busy1, owner1, err1});
        end
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int cyc, n, dv_n, done_n, gap_n;
        exp_t e;
        req0 = 4'b0100; rd0[47:32] = 16'hA5C3;
        sb.push_back({3'd2, 16'hA5C3});
        wait_grant(0, 10, cyc);
        req0 = '0;
        tests++;
        if (cyc !== 1) begin fails++; $display("FAIL single_latency: got %0d required 1", cyc); end
        tests++;
        if (grant0 !== 4'b0100) begin fails++; $display("FAIL single_grant: got %b required 0100", grant0); end
        e = sb.pop_front();
        tests++;
        if (owner0 !== e.owner || data0 !== e.data) begin
            fails++; $display("FAIL single_word: got %0d/%h required %0d/%h", owner0, data0, e.owner, e.data);
        end
        n = 0; dv_n = 0; done_n = 0; gap_n = 0;
        while (busy0 && n < 500) begin
            if (dv0) dv_n++;
            if (done0) done_n++;
            if (done_n > 0) gap_n++;
            @(negedge clk); n++;
        end
        tests++;
        if (dv_n !== 2) begin fails++; $display("FAIL single_dv_len: got %0d required 2", dv_n); end
        tests++;
        if (done_n !== 1) begin fails++; $display("FAIL single_done_count: got %0d required 1", done_n); end
        tests++;
        if (gap_n !== 16) begin fails++; $display("FAIL single_gap_len: got %0d required 16", gap_n); end
        tests++;
        if (busy0 !== 1'b0 || data0 !== 16'hA5C3) begin
            fails++; $display("FAIL single_after: got busy %b data %h required 0 a5c3", busy0, data0);
        end
    endtask

    task automatic test_contention;
        int cyc, n;
        exp_t e;
        pulse_reset0();
        rd0 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 5; i++) sb.push_back({3'(i % 4), 16'(((i % 4) + 1) * 16'h1111)});
        req0 = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(0, 300, cyc);
            if (i == 4) req0 = '0;
            e = sb.pop_front();
            tests++;
            if (cyc < 0 || grant0 !== 4'(1 << e.owner) || owner0 !== e.owner || data0 !== e.data) begin
                fails++;
                $display("FAIL contention_%0d: got grant %b owner %0d data %h required owner %0d data %h",
                         i, grant0, owner0, data0, e.owner, e.data);
            end
            @(negedge clk);
        end
        wait_idle0(500, n);
    endtask

    task automatic test_fixed_prio;
        int cyc, n;
        exp_t e;
        logic [2:0] seq [4];
`ifdef DAC_ARB_FIXED_PRIO_EN
        seq = '{3'd1, 3'd1, 3'd1, 3'd1};
`else
        seq = '{3'd1, 3'd3, 3'd1, 3'd3};
`endif
        pulse_reset0();
        rd0 = {16'hB003, 16'h0000, 16'hB001, 16'h0000};
        for (int i = 0; i < 4; i++) sb.push_back({seq[i], (seq[i] == 3'd1) ? 16'hB001 : 16'hB003});
        req0 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            wait_grant(0, 300, cyc);
            if (i == 3) req0 = '0;
            e = sb.pop_front();
            tests++;
            if (cyc < 0 || grant0 !== 4'(1 << e.owner) || owner0 !== e.owner || data0 !== e.data) begin
                fails++;
                $display("FAIL prio_%0d: got grant %b owner %0d data %h required owner %0d data %h",
                         i, grant0, owner0, data0, e.owner, e.data);
            end
            @(negedge clk);
        end
        wait_idle0(500, n);
    endtask

    task automatic test_timeout(input int mode, input logic [3:0] r, input logic [15:0] w, input string nm);
        int cyc, n, done_n;
        exp_t e;
        tests++;
        if (err0 !== 1'b0) begin fails++; $display("FAIL %s_pre_err: got %b required 0", nm, err0); end
        ser_mode = mode;
        req0 = r;
        for (int i = 0; i < 4; i++) if (r[i]) rd0[16*i +: 16] = w;
        sb.push_back({(r[1] ? 3'd1 : r[2] ? 3'd2 : 3'd0), w});
        wait_grant(0, 10, cyc);
        req0 = '0;
        e = sb.pop_front();
        tests++;
        if (cyc !== 1 || owner0 !== e.owner || data0 !== e.data) begin
            fails++; $display("FAIL %s_grant: got cyc %0d owner %0d data %h required 1 %0d %h", nm, cyc, owner0, data0, e.owner, e.data);
        end
        n = 0; done_n = 0;
        while (!err0 && n < 2200) begin
            if (done0) done_n++;
            @(negedge clk); n++;
        end
        tests++;
        if (err0 !== 1'b1 || n < 2045 || n > 2055) begin
            fails++; $display("FAIL %s_abort: got err %b after %0d cycles required 1 after about 2050", nm, err0, n);
        end
        wait_idle0(100, n);
        tests++;
        if (done_n !== 0 || busy0 !== 1'b0) begin
            fails++; $display("FAIL %s_no_done: got done %0d busy %b required 0 0", nm, done_n, busy0);
        end
        ser_mode = 0;
        repeat (3) @(negedge clk);
        req0 = 4'b0010; rd0[31:16] = w ^ 16'hFFFF;
        sb.push_back({3'd1, w ^ 16'hFFFF});
        wait_grant(0, 10, cyc);
        req0 = '0;
        e = sb.pop_front();
        tests++;
        if (cyc !== 1 || owner0 !== e.owner || data0 !== e.data) begin
            fails++; $display("FAIL %s_next_grant: got cyc %0d owner %0d data %h required 1 %0d %h", nm, cyc, owner0, data0, e.owner, e.data);
        end
        n = 0; done_n = 0;
        while (busy0 && n < 500) begin
            if (done0) done_n++;
            @(negedge clk); n++;
        end
        tests++;
        if (done_n !== 1 || err0 !== 1'b1) begin
            fails++; $display("FAIL %s_sticky: got done %0d err %b required 1 1", nm, done_n, err0);
        end
        err_clr0 = 1'b1;
        @(negedge clk);
        err_clr0 = 1'b0;
        tests++;
        if (err0 !== 1'b0) begin fails++; $display("FAIL %s_err_clr: got %b required 0", nm, err0); end
    endtask

    task automatic test_reset_mid;
        int cyc, n;
        exp_t e;
        req0 = 4'b0100; rd0[47:32] = 16'hC0DE;
        sb.push_back({3'd2, 16'hC0DE});
        wait_grant(0, 10, cyc);
        req0 = '0;
        e = sb.pop_front();
        n = 0;
        while (csn0 && n < 50) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        tests++;
        if (busy0 !== 1'b1 || owner0 !== e.owner || data0 !== e.data || csn0 !== 1'b0) begin
            fails++; $display("FAIL midreset_pre: got busy %b owner %0d data %h csn %b required 1 2 c0de 0", busy0, owner0, data0, csn0);
        end
        rst_n0 = 1'b0;
        #1;
        tests++;
        if ({grant0, done0, dv0, data0, busy0, owner0, err0} !== '0) begin
            fails++; $display("FAIL midreset_outputs: got %h required 0", {grant0, done0, dv0, data0, busy0, owner0, err0});
        end
        @(negedge clk);
        rst_n0 = 1'b1;
        rd0 = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        req0 = 4'b1111;
        sb.push_back({3'd0, 16'hD000});
        wait_grant(0, 10, cyc);
        req0 = '0;
        e = sb.pop_front();
        tests++;
        if (cyc !== 1 || grant0 !== 4'b0001 || owner0 !== e.owner || data0 !== e.data) begin
            fails++; $display("FAIL midreset_first: got cyc %0d grant %b data %h required 1 0001 %h", cyc, grant0, data0, e.data);
        end
        wait_idle0(500, n);
        tests++;
        if (busy0 !== 1'b0) begin fails++; $display("FAIL midreset_idle: got busy %b required 0", busy0); end
    endtask

    task automatic test_back_to_back;
        int cyc, n, m;
        exp_t e;
        rd1 = {16'hBB02, 16'hBB01};
        sb.push_back({3'd0, 16'hBB01});
        sb.push_back({3'd1, 16'hBB02});
        req1 = 2'b11;
        wait_grant(1, 10, cyc);
        e = sb.pop_front();
        tests++;
        if (cyc !== 1 || grant1 !== 2'b01 || owner1 !== e.owner || data1 !== e.data) begin
            fails++; $display("FAIL b2b_first: got cyc %0d grant %b owner %0d data %h required 1 01 0 bb01", cyc, grant1, owner1, data1);
        end
        n = 0;
        while (!done1 && n < 200) begin @(negedge clk); n++; end
        m = 0;
        while (!(|grant1) && m < 20) begin @(negedge clk); m++; end
        req1 = '0;
        e = sb.pop_front();
        tests++;
        if (!done1 && n >= 200) begin fails++; $display("FAIL b2b_done: got no done required one"); end
        tests++;
        if (m !== 2) begin fails++; $display("FAIL b2b_gap: got %0d cycles from done to grant required 2", m); end
        tests++;
        if (grant1 !== 2'b10 || owner1 !== e.owner || data1 !== e.data) begin
            fails++; $display("FAIL b2b_second: got grant %b owner %0d data %h required 10 1 bb02", grant1, owner1, data1);
        end
        n = 0;
        while (busy1 && n < 200) begin @(negedge clk); n++; end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fixed_prio();
        test_timeout(1, 4'b0001, 16'h7E01, "to_start");
        test_timeout(2, 4'b0100, 16'h7E03, "to_end");
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
